mouse_step_scheduler: RTL and testbench

//  Buffers host mouse packets (9-bit signed dX/dY plus a toggle strobe from the generic mouse module).

---
 rtl/mouse_pkg.sv | 42 ++++
 rtl/mouse_axis_acc.sv | 74 +++++++
 rtl/mouse_step_scheduler.sv | 118 +++++++++++
 tb/tb_mouse_step_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and helpers for the mouse step scheduler: port modes, slot FSM states,
// quadrature sequencing and saturating accumulation.
package mouse_pkg;

   localparam int DELTA_W = 9;

   typedef enum logic [1:0] {
      MT_OFF      = 2'd0,
      MT_KEMPSTON = 2'd1,
      MT_AMX      = 2'd2,
      MT_RSVD     = 2'd3
   } mouse_type_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XPH  = 2'd1,
      S_YPH  = 2'd2
   } step_state_e;

   // Forward walks 00->01->11->10->00; dir=1 walks the reverse way.
   function automatic logic [1:0] gray_next(input logic [1:0] phase, input logic dir);
      logic [1:0] r;
      case (phase)
         2'b00:   r = dir ? 2'b10 : 2'b01;
         2'b01:   r = dir ? 2'b00 : 2'b11;
         2'b11:   r = dir ? 2'b01 : 2'b10;
         default: r = dir ? 2'b11 : 2'b00;
      endcase
      return r;
   endfunction

   function automatic int sat_add(input int acc, input int d, input int lim);
      int s;
      s = acc + d;
      if (s > lim)
         s = lim;
      else if (s < -lim)
         s = -lim;
      return s;
   endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One motion axis: scales packet deltas, accumulates with saturation, emits single-count steps,
// tracks the wrapping 8-bit position and (with MOUSE_QUAD_EN) the quadrature phase.
module mouse_axis_acc
   import mouse_pkg::*;
#(
   parameter int ACC_W = 12
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   input  logic [DELTA_W-1:0] delta,
   input  logic               load,
   input  logic               clear,
   input  logic               step_en,
   input  logic [1:0]         scale,
   output logic               step,
   output logic               dir,
   output logic [7:0]         pos,
   output logic [1:0]         quad,
   output logic               nonzero
);

   localparam int LIMIT = (1 << (ACC_W - 1)) - 1;

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_d;
   logic [DELTA_W-1:0]      mag;
   logic [DELTA_W-1:0]      shifted;
   logic signed [DELTA_W:0] scaled;
   int                      addend;

   assign nonzero = (acc != '0);
   assign dir     = acc[ACC_W-1];
   assign step    = step_en && nonzero;

   // Shift the magnitude so negative deltas truncate toward zero like positive ones.
   always_comb begin
      mag     = delta[DELTA_W-1] ? (~delta + 9'd1) : delta;
      shifted = mag >> scale;
      scaled  = delta[DELTA_W-1] ? -$signed({1'b0, shifted}) : $signed({1'b0, shifted});
      addend  = 0;
      if (load)
         addend = int'(scaled);
      if (step)
         addend = dir ? addend + 1 : addend - 1;
      acc_d = ACC_W'(sat_add(int'(acc), addend, LIMIT));
   end

   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         acc <= '0;
         pos <= '0;
      end else begin
         acc <= clear ? '0 : acc_d;
         if (step)
            pos <= dir ? pos - 8'd1 : pos + 8'd1;
      end
   end

`ifdef MOUSE_QUAD_EN
   logic [1:0] phase;

   always_ff @(posedge clk_sys) begin
      if (!reset_n)
         phase <= 2'b00;
      else if (step)
         phase <= gray_next(phase, dir);
   end

   assign quad = phase;
`else
   assign quad = 2'b00;
`endif

endmodule

// File: rtl/mouse_step_scheduler.sv
// Buffers host mouse packets and drains them as paced X-then-Y single steps per STEP_DIV slot.
// Quadrature outputs are live only when MOUSE_QUAD_EN is defined, otherwise tied to 00.
module mouse_step_scheduler
   import mouse_pkg::*;
#(
   parameter int STEP_DIV = 1000,
   parameter int ACC_W    = 12
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [8:0] mouse_x,
   input  logic [8:0] mouse_y,
   input  logic       mouse_strobe,
   input  logic       mouse_left,
   input  logic       mouse_right,
   input  logic [1:0] mouse_type,
   input  logic [1:0] scale,
   output logic [7:0] pos_x,
   output logic [7:0] pos_y,
   output logic [1:0] btn_n,
   output logic [1:0] quad_x,
   output logic [1:0] quad_y,
   output logic       x_step,
   output logic       x_dir,
   output logic       y_step,
   output logic       y_dir,
   output logic       busy
);

   localparam int CW = $clog2(STEP_DIV);

   logic        strobe_q;
   logic [1:0]  type_q;
   logic [CW-1:0] div_cnt;
   step_state_e state_q, state_d;
   logic        packet, tick, active, type_chg, clear;
   logic        x_en, y_en, x_nz, y_nz;

   assign packet   = (mouse_strobe != strobe_q);
   assign type_chg = (mouse_type != type_q);
   assign active   = (mouse_type == MT_KEMPSTON) || (mouse_type == MT_AMX);
   assign clear    = type_chg || !active;
   assign tick     = (div_cnt == CW'(STEP_DIV - 1));
   assign busy     = x_nz || y_nz;

   // Strobe and mode copies load from the live inputs in reset so release never looks like an event.
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         strobe_q <= mouse_strobe;
         type_q   <= mouse_type;
         div_cnt  <= '0;
         state_q  <= S_IDLE;
         btn_n    <= 2'b11;
      end else begin
         strobe_q <= mouse_strobe;
         type_q   <= mouse_type;
         div_cnt  <= tick ? '0 : div_cnt + CW'(1);
         state_q  <= state_d;
         btn_n    <= {~mouse_left, ~mouse_right};
      end
   end

   always_comb begin
      state_d = state_q;
      x_en    = 1'b0;
      y_en    = 1'b0;
      case (state_q)
         S_IDLE:  if (tick) state_d = S_XPH;
         S_XPH:   begin
            state_d = S_YPH;
            x_en    = 1'b1;
         end
         S_YPH:   begin
            state_d = S_IDLE;
            y_en    = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (type_chg)
         state_d = S_IDLE;
      // A step is suppressed while reset is asserted or the mode is changing/off.
      if (!reset_n || clear) begin
         x_en = 1'b0;
         y_en = 1'b0;
      end
   end

   mouse_axis_acc #(.ACC_W(ACC_W)) u_x (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .delta   (mouse_x),
      .load    (packet),
      .clear   (clear),
      .step_en (x_en),
      .scale   (scale),
      .step    (x_step),
      .dir     (x_dir),
      .pos     (pos_x),
      .quad    (quad_x),
      .nonzero (x_nz)
   );

   mouse_axis_acc #(.ACC_W(ACC_W)) u_y (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .delta   (mouse_y),
      .load    (packet),
      .clear   (clear),
      .step_en (y_en),
      .scale   (scale),
      .step    (y_step),
      .dir     (y_dir),
      .pos     (pos_y),
      .quad    (quad_y),
      .nonzero (y_nz)
   );

endmodule

// File: tb/tb_mouse_step_scheduler.sv
// Bench for mouse_step_scheduler: per-cycle reference model of slot pacing, saturation,
// wrapping positions and gray phases, plus directed scenarios.
module tb_mouse_step_scheduler;

   localparam int D   = 4;
   localparam int LIM = 2047;

   logic       clk_sys = 1'b0;
   logic       reset_n;
   logic [8:0] mouse_x, mouse_y;
   logic       mouse_strobe, mouse_left, mouse_right;
   logic [1:0] mouse_type, scale;
   logic [7:0] pos_x, pos_y;
   logic [1:0] btn_n, quad_x, quad_y;
   logic       x_step, x_dir, y_step, y_dir, busy;

   int errors = 0;
   int checks = 0;

   int k, mx, my, mpx, mpy, mqx, mqy, msx;
   logic [1:0] mbtn, prev_type;
   int nxs, nys;

   always #5 clk_sys = ~clk_sys;

   mouse_step_scheduler #(.STEP_DIV(D), .ACC_W(12)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .mouse_x(mouse_x), .mouse_y(mouse_y),
      .mouse_strobe(mouse_strobe), .mouse_left(mouse_left), .mouse_right(mouse_right),
      .mouse_type(mouse_type), .scale(scale), .pos_x(pos_x), .pos_y(pos_y), .btn_n(btn_n),
      .quad_x(quad_x), .quad_y(quad_y), .x_step(x_step), .x_dir(x_dir),
      .y_step(y_step), .y_dir(y_dir), .busy(busy)
   );

   function automatic int scaled_of(input int d, input int s);
      int m;
      m = (d < 0) ? -d : d;
      m = m >> s;
      return (d < 0) ? -m : m;
   endfunction

   function automatic int sat(input int v);
      if (v > LIM) return LIM;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   function automatic logic [1:0] exp_quad(input int idx);
      logic [1:0] g;
      g = 2'b00;
`ifdef MOUSE_QUAD_EN
      case (idx & 3)
         1: g = 2'b01;
         2: g = 2'b11;
         3: g = 2'b10;
         default: g = 2'b00;
      endcase
`endif
      return g;
   endfunction

   function automatic bit mode_on(input logic [1:0] t);
      return (t == 2'd1) || (t == 2'd2);
   endfunction

   task automatic model_init();
      k = 0; mx = 0; my = 0; mpx = 0; mpy = 0; mqx = 0; mqy = 0;
      mbtn = 2'b11; prev_type = mouse_type;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      reset_n = 1'b1;
      model_init();
   endtask

   // One clock: drive (at posedge+1), compare mid-cycle against the model, advance the model.
   task automatic cycle(input bit tog, input int dx, input int dy);
      bit ex, ey, chg;
      int sx, sy;
      if (tog) begin
         mouse_x = dx[8:0];
         mouse_y = dy[8:0];
         mouse_strobe = ~mouse_strobe;
      end
      #3;
      chg = (mouse_type != prev_type);
      ex = mode_on(mouse_type) && !chg && k > 0 && (k % D) == 0 && mx != 0;
      ey = mode_on(mouse_type) && !chg && k > 1 && (k % D) == 1 && my != 0;
      checks++;
      if (x_step !== ex) begin errors++; $display("FAIL x_step k=%0d got %b want %b", k, x_step, ex); end
      checks++;
      if (y_step !== ey) begin errors++; $display("FAIL y_step k=%0d got %b want %b", k, y_step, ey); end
      if (ex) begin
         checks++;
         if (x_dir !== (mx < 0)) begin errors++; $display("FAIL x_dir k=%0d got %b want %b", k, x_dir, (mx < 0)); end
      end
      if (ey) begin
         checks++;
         if (y_dir !== (my < 0)) begin errors++; $display("FAIL y_dir k=%0d got %b want %b", k, y_dir, (my < 0)); end
      end
      checks++;
      if (pos_x !== mpx[7:0]) begin errors++; $display("FAIL pos_x k=%0d got %0d want %0d", k, pos_x, mpx); end
      checks++;
      if (pos_y !== mpy[7:0]) begin errors++; $display("FAIL pos_y k=%0d got %0d want %0d", k, pos_y, mpy); end
      checks++;
      if (busy !== (mx != 0 || my != 0)) begin errors++; $display("FAIL busy k=%0d got %b want %b", k, busy, (mx != 0 || my != 0)); end
      checks++;
      if (btn_n !== mbtn) begin errors++; $display("FAIL btn_n k=%0d got %b want %b", k, btn_n, mbtn); end
      checks++;
      if (quad_x !== exp_quad(mqx) || quad_y !== exp_quad(mqy)) begin
         errors++;
         $display("FAIL quad k=%0d got %b/%b want %b/%b", k, quad_x, quad_y, exp_quad(mqx), exp_quad(mqy));
      end
      if (x_step === 1'b1) nxs++;
      if (y_step === 1'b1) nys++;
      sx = ex ? ((mx > 0) ? 1 : -1) : 0;
      sy = ey ? ((my > 0) ? 1 : -1) : 0;
      if (ex) msx++;
      if (!mode_on(mouse_type) || chg) begin
         mx = 0;
         my = 0;
      end else begin
         mx = sat(mx + (tog ? scaled_of(dx, int'(scale)) : 0) - sx);
         my = sat(my + (tog ? scaled_of(dy, int'(scale)) : 0) - sy);
      end
      mpx = (mpx + sx) & 255;  mpy = (mpy + sy) & 255;
      mqx = (mqx + sx) & 3;    mqy = (mqy + sy) & 3;
      mbtn = {~mouse_left, ~mouse_right};
      prev_type = mouse_type;
      k++;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(0, 0, 0);
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((mx != 0 || my != 0) && n < bound) begin
         cycle(0, 0, 0);
         n++;
      end
      if (mx != 0 || my != 0) begin
         errors++;
         $display("FAIL drain_timeout after %0d cycles acc=%0d/%0d", n, mx, my);
      end
      idle(1);
   endtask

   task automatic align(input int r);
      while ((k % D) != r) cycle(0, 0, 0);
   endtask

   task automatic test_reset();
      mouse_left = 1'b1;
      mouse_strobe = ~mouse_strobe;
      reset_n = 1'b0;
      repeat (2) @(posedge clk_sys);
      #1;
      checks++; if (pos_x !== 8'd0 || pos_y !== 8'd0) begin errors++; $display("FAIL reset_pos got %0d/%0d want 0/0", pos_x, pos_y); end
      checks++; if (btn_n !== 2'b11) begin errors++; $display("FAIL reset_btn got %b want 11", btn_n); end
      checks++; if (x_step !== 1'b0 || y_step !== 1'b0) begin errors++; $display("FAIL reset_step got %b%b want 00", x_step, y_step); end
      checks++; if (x_dir !== 1'b0 || y_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got %b%b want 00", x_dir, y_dir); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (quad_x !== 2'b00 || quad_y !== 2'b00) begin errors++; $display("FAIL reset_quad got %b/%b want 00/00", quad_x, quad_y); end
      reset_n = 1'b1;
      model_init();
      mouse_left = 1'b0;
      idle(2 * D);
   endtask

   task automatic test_plus3();
      nxs = 0;
      cycle(1, 3, 0);
      drain(100);
      checks++; if (nxs != 3) begin errors++; $display("FAIL plus3_steps got %0d want 3", nxs); end
      checks++; if (pos_x !== 8'd3) begin errors++; $display("FAIL plus3_pos got %0d want 3", pos_x); end
   endtask

   task automatic test_neg_wrap();
      cycle(1, -2, 0);
      drain(100);
      checks++; if (pos_x !== 8'd1) begin errors++; $display("FAIL neg_pos1 got %0d want 1", pos_x); end
      nxs = 0;
      cycle(1, -2, 0);
      drain(100);
      checks++; if (nxs != 2) begin errors++; $display("FAIL neg_steps got %0d want 2", nxs); end
      checks++; if (pos_x !== 8'd255) begin errors++; $display("FAIL neg_wrap got %0d want 255", pos_x); end
   endtask

   task automatic test_scale();
      scale = 2'd3;
      nxs = 0;
      cycle(1, -7, 0);
      idle(2 * D);
      checks++; if (nxs != 0 || busy !== 1'b0) begin errors++; $display("FAIL scale_trunc steps=%0d busy=%b want 0/0", nxs, busy); end
      cycle(1, 16, 0);
      drain(100);
      checks++; if (nxs != 2) begin errors++; $display("FAIL scale_16 got %0d want 2", nxs); end
      scale = 2'd0;
   endtask

   task automatic test_saturation();
      nxs = 0;
      msx = 0;
      repeat (20) cycle(1, 255, 0);
      drain(3000 * D);
      checks++; if (nxs != msx) begin errors++; $display("FAIL sat_steps got %0d want %0d", nxs, msx); end
   endtask

   task automatic test_simultaneous();
      align(1);
      cycle(1, 5, 0);
      align(0);
      nxs = 0;
      cycle(1, 1, 0);
      drain(100);
      checks++; if (nxs != 6) begin errors++; $display("FAIL simul_steps got %0d want 6", nxs); end
   endtask

   task automatic test_mode_change();
      int py;
      align(2);
      cycle(1, 0, 10);
      align(1);
      py = mpy;
      nys = 0;
      mouse_type = 2'd2;
      cycle(0, 0, 0);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mode_clear busy got %b want 0", busy); end
      checks++; if (pos_y !== py[7:0]) begin errors++; $display("FAIL mode_pos_y got %0d want %0d", pos_y, py); end
      idle(2 * D);
      checks++; if (nys != 0) begin errors++; $display("FAIL mode_ystep got %0d want 0", nys); end
      for (int t = 0; t < 2; t++) begin
         mouse_type = (t == 0) ? 2'd0 : 2'd3;
         nxs = 0;
         idle(3);
         cycle(1, 50, -50);
         idle(2 * D);
         checks++; if (nxs != 0 || busy !== 1'b0) begin errors++; $display("FAIL mode_off type=%0d steps=%0d busy=%b want 0/0", mouse_type, nxs, busy); end
      end
      mouse_type = 2'd1;
      idle(3);
   endtask

   task automatic test_quad();
      logic [1:0] qs [4];
      int n0, guard;
      mouse_type = 2'd1;
      apply_reset();
`ifdef MOUSE_QUAD_EN
      qs = '{2'b01, 2'b11, 2'b10, 2'b00};
`else
      qs = '{2'b00, 2'b00, 2'b00, 2'b00};
`endif
      cycle(1, 4, 0);
      for (int i = 0; i < 4; i++) begin
         n0 = nxs;
         guard = 0;
         while (nxs == n0 && guard < 4 * D) begin cycle(0, 0, 0); guard++; end
         checks++; if (quad_x !== qs[i]) begin errors++; $display("FAIL quad_plus%0d got %b want %b", i + 1, quad_x, qs[i]); end
      end
      cycle(1, -1, 0);
      n0 = nxs;
      guard = 0;
      while (nxs == n0 && guard < 4 * D) begin cycle(0, 0, 0); guard++; end
`ifdef MOUSE_QUAD_EN
      checks++; if (quad_x !== 2'b10) begin errors++; $display("FAIL quad_minus got %b want 10", quad_x); end
`else
      checks++; if (quad_x !== 2'b00) begin errors++; $display("FAIL quad_minus got %b want 00", quad_x); end
`endif
      idle(D);
   endtask

   task automatic test_random();
      mouse_type = 2'd2;
      idle(3);
      for (int i = 0; i < 600; i++) begin
         mouse_left  = 1'($urandom_range(0, 1));
         mouse_right = 1'($urandom_range(0, 1));
         scale       = 2'($urandom_range(0, 3));
         cycle($urandom_range(0, 4) == 0, int'($urandom_range(0, 511)) - 256,
               int'($urandom_range(0, 511)) - 256);
      end
      mouse_left  = 1'b0;
      mouse_right = 1'b0;
      scale = 2'd0;
      drain(3000 * D);
   endtask

   task automatic test_reset_mid_slot();
      cycle(1, 20, 20);
      while ((k % D) != 0 || mx == 0) cycle(0, 0, 0);
      reset_n = 1'b0;
      #3;
      checks++; if (x_step !== 1'b0 || y_step !== 1'b0) begin errors++; $display("FAIL midreset_step got %b%b want 00", x_step, y_step); end
      @(posedge clk_sys);
      #1;
      checks++; if (pos_x !== 8'd0 || pos_y !== 8'd0) begin errors++; $display("FAIL midreset_pos got %0d/%0d want 0/0", pos_x, pos_y); end
      checks++; if (busy !== 1'b0 || btn_n !== 2'b11) begin errors++; $display("FAIL midreset_state busy=%b btn=%b want 0/11", busy, btn_n); end
      reset_n = 1'b1;
      model_init();
      idle(2 * D);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      mouse_x = '0; mouse_y = '0; mouse_strobe = 1'b0;
      mouse_left = 1'b0; mouse_right = 1'b0;
      mouse_type = 2'd1; scale = 2'd0;
      nxs = 0; nys = 0; msx = 0;
      model_init();
      test_reset();
      test_plus3();
      test_neg_wrap();
      test_scale();
      test_saturation();
      test_simultaneous();
      test_mode_change();
      test_quad();
      test_random();
      test_reset_mid_slot();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
